// File: rtl/vga_sync_gen.sv
// VGA timing generator: clock-enable divider plus horizontal/vertical pixel counters,
// with registered active-low syncs aligned to the counters and decoded video/frame flags.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int DIV       = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS   = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS   = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_LO   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_HI   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]    VS_LO   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_HI   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_hsync;
  logic          r_vsync;

  logic          w_tick;
  logic          w_x_last;
  logic          w_y_last;
  logic [9:0]    w_x_next;
  logic [9:0]    w_y_next;

  always_comb begin
    w_tick   = (r_div == DIV_MAX);
    w_x_last = (r_x == H_MAX);
    w_y_last = (r_y == V_MAX);
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_tick) begin
      w_x_next = w_x_last ? 10'd0 : r_x + 10'd1;
      if (w_x_last) begin
        w_y_next = w_y_last ? 10'd0 : r_y + 10'd1;
      end
    end
  end

  // Syncs are decoded from the next counter values so they switch on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_div   <= w_tick ? '0 : r_div + DIV_ONE;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= !((w_x_next >= HS_LO) && (w_x_next <= HS_HI));
      r_vsync <= !((w_y_next >= VS_LO) && (w_y_next <= VS_HI));
    end
  end

  assign p_tick      = w_tick;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = (r_x < H_VIS) && (r_y < V_VIS);
  assign frame_start = w_tick && w_x_last && w_y_last;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter DIV, default 4, clk cycles per pixel (≥2).
REQ-010 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-011 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port hsync  output  1  horizontal sync, active-low, registered.
REQ-013 SHALL have port vsync  output  1  vertical sync, active-low, registered.
REQ-014 SHALL have port video_on  output  1  high while (pixel_x < H_DISPLAY) and (pixel_y < V_DISPLAY).
REQ-015 SHALL have port p_tick  output  1  one-clk pulse marking each pixel-clock advance.
REQ-016 SHALL have port pixel_x  output  10  current horizontal count, feeds the character-address generator.
REQ-017 SHALL have port pixel_y  output  10  current vertical count, feeds the character-address generator.
REQ-018 SHALL have port frame_start  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-019 SHALL contain a mod-DIV divider counter; p_tick = 1 iff divider == DIV-1.
REQ-020 SHALL hold pixel_x/pixel_y in registers; they change only on a clk edge where p_tick = 1.
REQ-021 On p_tick: pixel_x SHALL increment; at H_TOTAL-1 (H_TOTAL = sum of H params, 800) it SHALL wrap to 0.
REQ-022 pixel_y SHALL increment only on p_tick with pixel_x == H_TOTAL-1; at V_TOTAL-1 (525) it SHALL wrap to 0.
REQ-023 hsync SHALL be 0 exactly while pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), else 1.
REQ-024 vsync SHALL be 0 exactly while pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), else 1.
REQ-025 hsync/vsync SHALL be registered from next-state counter values so they change on the same clk edge as pixel_x/pixel_y (zero skew, glitch-free).
REQ-026 video_on SHALL be a decode of the registered counters, zero latency relative to pixel_x/pixel_y.
REQ-027 frame_start SHALL be high for the single clk cycle where p_tick = 1, pixel_x == H_TOTAL-1 and pixel_y == V_TOTAL-1.
REQ-028 Counter values SHALL never exceed H_TOTAL-1 / V_TOTAL-1; no out-of-range state is reachable.
REQ-029 Line period SHALL be H_TOTAL*DIV clks (3200); frame period V_TOTAL*H_TOTAL*DIV clks (1,680,000).

Reset
REQ-030 On any clk edge with reset = 1: divider = 0, pixel_x = 0, pixel_y = 0, hsync = 1, vsync = 1.
REQ-031 Consequently during/after reset: p_tick = 0, frame_start = 0, video_on = 1.
REQ-032 Reset asserted mid-frame (any counter state, including inside a sync pulse) SHALL take precedence over counting and restore REQ-030 values on that edge.
REQ-033 After reset release, first p_tick SHALL occur on the DIV-th clk cycle (cycle 4), pixel_x becoming 1 at that edge.

Verification
REQ-034 Reset 3 clks, release -> p_tick high on cycles 4, 8, 12...; pixel_x = 1, 2, 3 after those edges; pixel_y = 0; hsync = vsync = 1.
REQ-035 Run one line -> hsync falls when pixel_x becomes 656, low for 384 clks, rises when pixel_x becomes 752; pixel_x wraps 799->0 and pixel_y 0->1 on the same edge.
REQ-036 Run one frame -> vsync low exactly for lines 490-491 (6400 clks); frame_start single pulse at clk 1,680,000 after release; pixel_y wraps 524->0.
REQ-037 Check video_on -> 1 for pixel_x 0..639 with pixel_y 0..479; 0 at pixel_x = 640 or pixel_y = 480; 307,200 active p_ticks per frame.
REQ-038 Assert reset for 1 clk while pixel_x = 700, pixel_y = 490 (hsync = vsync = 0) -> next edge: all counters 0, hsync = vsync = 1, no frame_start pulse.
REQ-039 Parameterize DIV = 2, H/V reduced (e.g. 8/2/2/2, 4/1/1/1) -> periods and sync windows scale per REQ-021..029.
